pipe_hazard_ctrl: RTL

Pipeline sequencing controller for the five-stage CPU. It drives the active-low write enables and bubble/flush controls of the PC and the IF/ID, ID/EX and EX/MEM pipeline registers, where a write enable of 0 means load. It resolves four conditions: load-use stalls, taken-branch flushes, multi-cycle mul/div occupancy of EX, and data-memory wait. It also keeps a saturating stall-cycle counter for performance measurement.

---
 rtl/pipe_hazard_ctrl.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/pipe_hazard_ctrl.sv
// rtl/pipe_hazard_ctrl.sv - pipeline sequencing and hazard controller for the five-stage CPU
//
// Drives the active-low write enables (0 = load) and NOP-insertion controls of
// the PC, IF/ID, ID/EX and EX/MEM registers. Resolves load-use stalls,
// taken-branch flushes, multi-cycle mul/div occupancy of EX and data-memory
// wait, and counts front-end stall cycles.
//
// Ports:
//   clk, clr                       clock, async active-high reset
//   id_rs, id_rt, id_use_rs/rt     ID-stage source operands and their use flags
//   id_mdu_start                   ID instruction is a mul/div
//   ex_is_load, ex_rd              EX-stage load flag and destination register
//   ex_branch_taken                branch/jump resolved taken in EX
//   mem_wait                       data memory not ready, freeze everything
//   *_wen_n                        active-low pipeline register write enables
//   ifid_flush, idex_bubble,
//   exmem_bubble                   load NOP into the named register
//   mdu_busy                       registered, high while a mul/div owns EX
//   mdu_done                       final mul/div cycle, EX result valid
//   stall_cycles                   saturating count of cycles with pc_wen_n=1

module pipe_hazard_ctrl #(
  parameter int MDU_LAT = 32,
  parameter int CNT_W   = 6
) (
  input  logic        clk,
  input  logic        clr,
  input  logic [4:0]  id_rs,
  input  logic [4:0]  id_rt,
  input  logic        id_use_rs,
  input  logic        id_use_rt,
  input  logic        id_mdu_start,
  input  logic        ex_is_load,
  input  logic [4:0]  ex_rd,
  input  logic        ex_branch_taken,
  input  logic        mem_wait,
  output logic        pc_wen_n,
  output logic        ifid_wen_n,
  output logic        idex_wen_n,
  output logic        exmem_wen_n,
  output logic        ifid_flush,
  output logic        idex_bubble,
  output logic        exmem_bubble,
  output logic        mdu_busy,
  output logic        mdu_done,
  output logic [31:0] stall_cycles
);

  typedef enum logic {
    S_RUN = 1'b0,
    S_MDU = 1'b1
  } state_t;

  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(MDU_LAT - 1);

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [31:0]        stall_q, stall_d;
  logic               load_use;

  // Register x0 is hard-wired zero, so a load targeting it never creates a hazard.
  assign load_use = ex_is_load && (ex_rd != 5'd0) &&
                    ((id_use_rs && (id_rs == ex_rd)) ||
                     (id_use_rt && (id_rt == ex_rd)));

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    pc_wen_n     = 1'b0;
    ifid_wen_n   = 1'b0;
    idex_wen_n   = 1'b0;
    exmem_wen_n  = 1'b0;
    ifid_flush   = 1'b0;
    idex_bubble  = 1'b0;
    exmem_bubble = 1'b0;
    mdu_done     = 1'b0;

    if (clr) begin
      // Keep every pipeline register frozen while reset is held.
      pc_wen_n    = 1'b1;
      ifid_wen_n  = 1'b1;
      idex_wen_n  = 1'b1;
      exmem_wen_n = 1'b1;
    end else begin
      unique case (state_q)
        S_RUN: begin
          if (mem_wait) begin
            pc_wen_n    = 1'b1;
            ifid_wen_n  = 1'b1;
            idex_wen_n  = 1'b1;
            exmem_wen_n = 1'b1;
          end else if (ex_branch_taken) begin
            // Squash the two younger instructions; a mul/div among them never starts.
            ifid_flush  = 1'b1;
            idex_bubble = 1'b1;
          end else if (load_use) begin
            // Hold IF and ID one cycle; the load moves on to MEM where forwarding reaches it.
            pc_wen_n    = 1'b1;
            ifid_wen_n  = 1'b1;
            idex_bubble = 1'b1;
          end else if (id_mdu_start) begin
            state_d = S_MDU;
            cnt_d   = CNT_INIT;
          end
        end

        S_MDU: begin
          if (mem_wait) begin
            pc_wen_n    = 1'b1;
            ifid_wen_n  = 1'b1;
            idex_wen_n  = 1'b1;
            exmem_wen_n = 1'b1;
          end else if (cnt_q != '0) begin
            // Mul/div keeps EX; feed NOPs downstream so MEM/WB drain.
            pc_wen_n     = 1'b1;
            ifid_wen_n   = 1'b1;
            idex_wen_n   = 1'b1;
            exmem_bubble = 1'b1;
            cnt_d        = cnt_q - 1'b1;
          end else begin
            mdu_done = 1'b1;
            state_d  = S_RUN;
          end
        end

        default: state_d = S_RUN;
      endcase
    end
  end

  always_comb begin
    stall_d = stall_q;
    if (pc_wen_n && (stall_q != 32'hFFFF_FFFF)) begin
      stall_d = stall_q + 32'd1;
    end
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_q <= S_RUN;
      cnt_q   <= '0;
      stall_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      stall_q <= stall_d;
    end
  end

  assign mdu_busy     = (state_q == S_MDU);
  assign stall_cycles = stall_q;

endmodule
